// File: rtl/picorv_mem_arbiter.sv
// picorv_mem_arbiter: two-port round-robin arbiter for the PicoRV32 native memory bus,
// with a per-transfer watchdog that aborts a hung downstream transfer.
module picorv_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        s0_valid,
    input  logic        s0_instr,
    input  logic [31:0] s0_addr,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    output logic        s0_ready,
    output logic [31:0] s0_rdata,
    input  logic        s1_valid,
    input  logic        s1_instr,
    input  logic [31:0] s1_addr,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_wstrb,
    output logic        s1_ready,
    output logic [31:0] s1_rdata,
    output logic        m_valid,
    output logic        m_instr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err,
    input  logic        err_clr
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
    state_t state;
    logic last;
    logic [CNT_W-1:0] cnt;
    logic abort, done, pick0, pick1;
    always_comb begin
        abort = TIMEOUT_CYCLES != 0 && state != IDLE && !m_ready && cnt == LIMIT;
        done = m_ready || abort;
        // last=1 means port 1 was served most recently, so port 0 wins a tie
        pick0 = s0_valid && (!s1_valid || last);
        pick1 = s1_valid && !pick0;
        s0_ready = HRESETn && state == BUSY0 && done;
        s1_ready = HRESETn && state == BUSY1 && done;
        s0_rdata = state == BUSY0 ? (abort ? ERR_RDATA : m_rdata) : '0;
        s1_rdata = state == BUSY1 ? (abort ? ERR_RDATA : m_rdata) : '0;
    end
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= IDLE;
            last <= 1'b1;
            m_valid <= 1'b0;
            m_instr <= 1'b0;
            m_addr <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
            grant <= '0;
            timeout_err <= 1'b0;
            cnt <= '0;
        end else begin
            timeout_err <= abort || (timeout_err && !err_clr);
            if (state == IDLE) begin
                if (pick0 || pick1) begin
                    state <= pick0 ? BUSY0 : BUSY1;
                    last <= pick1;
                    m_valid <= 1'b1;
                    grant <= {pick1, pick0};
                    m_instr <= pick0 ? s0_instr : s1_instr;
                    m_addr <= pick0 ? s0_addr : s1_addr;
                    m_wdata <= pick0 ? s0_wdata : s1_wdata;
                    m_wstrb <= pick0 ? s0_wstrb : s1_wstrb;
                    cnt <= '0;
                end
            end else if (done) begin
                state <= IDLE;
                m_valid <= 1'b0;
                grant <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// tb_picorv_mem_arbiter: directed and random checks of the arbiter against a
// transaction-level model (owner, busy-cycle index, last winner).
module tb_picorv_mem_arbiter;
    localparam int T = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    logic clk = 1'b0;
    logic HRESETn;
    logic s0_valid, s0_instr, s0_ready, s1_valid, s1_instr, s1_ready;
    logic [31:0] s0_addr, s0_wdata, s0_rdata, s1_addr, s1_wdata, s1_rdata;
    logic [3:0] s0_wstrb, s1_wstrb, m_wstrb;
    logic m_valid, m_instr, m_ready, timeout_err, err_clr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0] grant;
    int cmps = 0, errs = 0;
    int owner = -1, last = 1, bc = 0, lat = 0, lat_fix = 0, pend0 = 0, pend1 = 0;
    int gq[$];
    logic [31:0] ea, ew, rd_fix;
    logic [3:0] es;
    logic ei, terr, fix_rd;

    picorv_mem_arbiter #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR), .CNT_W(16)) dut (
        .HCLK(clk), .HRESETn(HRESETn),
        .s0_valid(s0_valid), .s0_instr(s0_instr), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_wstrb(s0_wstrb), .s0_ready(s0_ready), .s0_rdata(s0_rdata),
        .s1_valid(s1_valid), .s1_instr(s1_instr), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_wstrb(s1_wstrb), .s1_ready(s1_ready), .s1_rdata(s1_rdata),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
        .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check at negedge, advance the model at posedge.
    task automatic step();
        logic to, r0, r1;
        int w;
        s0_valid = HRESETn && pend0 > 0;
        s1_valid = HRESETn && pend1 > 0;
        m_ready = owner >= 0 && bc == lat;
        m_rdata = fix_rd ? rd_fix : $urandom;
        @(negedge clk);
        to = owner >= 0 && !m_ready && bc == T - 1;
        r0 = HRESETn && owner == 0 && (m_ready || to);
        r1 = HRESETn && owner == 1 && (m_ready || to);
        chk("s0_ready", {31'b0, s0_ready}, {31'b0, r0});
        chk("s1_ready", {31'b0, s1_ready}, {31'b0, r1});
        if (HRESETn) begin
            chk("m_valid", {31'b0, m_valid}, {31'b0, owner >= 0});
            chk("grant", {30'b0, grant}, owner == 0 ? 32'd1 : owner == 1 ? 32'd2 : 32'd0);
            chk("timeout_err", {31'b0, timeout_err}, {31'b0, terr});
            chk("s0_rdata", s0_rdata, owner == 0 ? (to ? ERR : m_rdata) : 32'd0);
            chk("s1_rdata", s1_rdata, owner == 1 ? (to ? ERR : m_rdata) : 32'd0);
            if (owner >= 0) begin
                chk("m_addr", m_addr, ea);
                chk("m_wdata", m_wdata, ew);
                chk("m_wstrb", {28'b0, m_wstrb}, {28'b0, es});
                chk("m_instr", {31'b0, m_instr}, {31'b0, ei});
            end
        end
        @(posedge clk);
        if (!HRESETn) begin
            owner = -1;
            last = 1;
            terr = 1'b0;
        end else begin
            terr = to ? 1'b1 : err_clr ? 1'b0 : terr;
            if (owner >= 0) begin
                if (m_ready || to) owner = -1;
                else bc++;
            end else begin
                w = (s0_valid && s1_valid) ? 1 - last : s0_valid ? 0 : s1_valid ? 1 : -1;
                if (w >= 0) begin
                    owner = w;
                    last = w;
                    bc = 0;
                    gq.push_back(w);
                    lat = lat_fix >= 0 ? lat_fix : int'($urandom_range(0, 11));
                    ea = w == 0 ? s0_addr : s1_addr;
                    ew = w == 0 ? s0_wdata : s1_wdata;
                    es = w == 0 ? s0_wstrb : s1_wstrb;
                    ei = w == 0 ? s0_instr : s1_instr;
                end
            end
            if (r0) pend0--;
            if (r1) pend1--;
        end
        #1;
    endtask

    task automatic run(input string tag);
        for (int i = 0; i < 100 && (pend0 > 0 || pend1 > 0 || owner >= 0); i++) step();
        chk(tag, pend0 + pend1 + (owner >= 0 ? 1 : 0), 0);
    endtask

    task automatic chk_gq(input string tag, input int n, input int first);
        chk({tag, "_len"}, gq.size(), n);
        for (int i = 0; i < n; i++)
            chk(tag, gq.size() > i ? gq[i] : -1, (first + i) % 2);
    endtask

    initial begin
        int n;
        HRESETn = 1'b0; err_clr = 1'b0; fix_rd = 1'b1; rd_fix = 32'h1234_5678; terr = 1'b0;
        s0_instr = 1'b0; s0_addr = '0; s0_wdata = '0; s0_wstrb = '0;
        s1_instr = 1'b0; s1_addr = '0; s1_wdata = '0; s1_wstrb = '0;
        m_ready = 1'b0; m_rdata = '0;
        step();
        step();
        chk("rst_m_valid", {31'b0, m_valid}, 0);
        chk("rst_grant", {30'b0, grant}, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_wstrb", {28'b0, m_wstrb}, 0);
        chk("rst_m_instr", {31'b0, m_instr}, 0);
        chk("rst_terr", {31'b0, timeout_err}, 0);
        HRESETn = 1'b1;
        // port-0 read completing three cycles after m_valid
        lat_fix = 3; s0_addr = 32'h4000_0000; pend0 = 1;
        run("t1_done");
        // simultaneous requests straight after reset, then continuous requests
        HRESETn = 1'b0; step(); HRESETn = 1'b1;
        gq.delete(); lat_fix = 0; pend0 = 1; pend1 = 1;
        run("t2_done");
        chk_gq("t2_order", 2, 0);
        gq.delete(); pend0 = 2; pend1 = 2;
        run("t2b_done");
        chk_gq("t2b_alt", 4, 0);
        // port-1 write with fields changed illegally mid-transfer
        lat_fix = 5; s1_addr = 32'h4000_0100; s1_wdata = 32'hA5A5_A5A5; s1_wstrb = 4'hF; pend1 = 1;
        step();
        chk("t3_addr", m_addr, 32'h4000_0100);
        chk("t3_wdata", m_wdata, 32'hA5A5_A5A5);
        step();
        s1_addr = 32'hFFFF_0000; s1_wdata = 32'h0; s1_wstrb = 4'h1; s1_instr = 1'b1;
        run("t3_done");
        // watchdog abort, clear, then abort with clear held
        lat_fix = 1000; pend0 = 1; n = 0;
        for (int i = 0; i < 50 && pend0 > 0; i++) begin step(); n++; end
        chk("t4_cycles", n, T + 1);
        step();
        chk("t4_terr_set", {31'b0, timeout_err}, 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t4_terr_clr", {31'b0, timeout_err}, 0);
        err_clr = 1'b1; pend0 = 1;
        run("t4b_done");
        err_clr = 1'b0;
        chk("t4_set_wins", {31'b0, timeout_err}, 1);
        // m_ready exactly in the abort cycle: normal completion wins
        err_clr = 1'b1; step(); err_clr = 1'b0;
        rd_fix = 32'h0BAD_F00D; lat_fix = T - 1; pend0 = 1;
        run("t6_done");
        chk("t6_terr", {31'b0, timeout_err}, 0);
        // reset during BUSY1 while m_ready is high
        lat_fix = 2; pend1 = 1;
        step(); step(); step();
        HRESETn = 1'b0; pend1 = 0; step(); HRESETn = 1'b1;
        chk("t5_m_valid", {31'b0, m_valid}, 0);
        chk("t5_grant", {30'b0, grant}, 0);
        gq.delete(); lat_fix = 0; pend0 = 1; pend1 = 1;
        run("t5_done");
        chk_gq("t5_order", 2, 0);
        // random traffic with random latencies, including aborts
        lat_fix = -1; fix_rd = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (pend0 == 0 && $urandom_range(0, 3) == 0) begin
                pend0 = 1; s0_addr = $urandom; s0_wdata = $urandom;
                s0_wstrb = 4'($urandom); s0_instr = 1'($urandom);
            end
            if (pend1 == 0 && $urandom_range(0, 3) == 0) begin
                pend1 = 1; s1_addr = $urandom; s1_wdata = $urandom;
                s1_wstrb = 4'($urandom); s1_instr = 1'($urandom);
            end
            err_clr = $urandom_range(0, 9) == 0;
            step();
        end
        err_clr = 1'b0;
        run("rand_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
